// File: rtl/vid_pkg.sv
// Shared widths, timing-register bundle and FSM states for the display timing generator.
// Helpers keep the window/wrap arithmetic identical wherever counters are compared.
package vid_pkg;

  localparam int CW   = 13;
  localparam int PW   = 6;
  localparam int CDW  = 8;
  localparam int PIXW = 3 * CDW;

  typedef struct packed {
    logic [CW-1:0] hsize;
    logic [CW-1:0] hend;
    logic [CW-1:0] hsync_start;
    logic [CW-1:0] hsync_end;
    logic [CW-1:0] vsize;
    logic [CW-1:0] vend;
    logic [CW-1:0] vsync_start;
    logic [CW-1:0] vsync_end;
    logic [PW-1:0] pcnt;
  } timing_cfg_t;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2
  } vtg_state_e;

  // Half-open window [lo,hi); lo==hi yields an empty window.
  function automatic logic in_window(input logic [CW-1:0] cnt,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] cnt,
                                             input logic [CW-1:0] total);
    return (cnt == total - CW'(1)) ? '0 : cnt + CW'(1);
  endfunction

endpackage

// File: rtl/vid_pix_div.sv
// Pixel-clock divider: o_tick is combinational, high one clock in every pcnt+1 while running.
// No backpressure; leaving run clears the phase so the first tick lands pcnt clocks after restart.
module vid_pix_div
  import vid_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_run,
  input  logic [PW-1:0] i_pcnt,
  output logic          o_tick
);

  logic [PW-1:0] r_divcnt;

  assign o_tick = i_run && (r_divcnt == i_pcnt);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run || o_tick) begin
      r_divcnt <= '0;
    end else begin
      r_divcnt <= r_divcnt + PW'(1);
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Display timing generator: h/v counters, sync/blank strobes, RGB from a show-ahead FIFO.
// Outputs lag their counter value by 1 clk and hold between ticks; an empty FIFO never stalls, it flags underflow.
module vid_timing_gen
  import vid_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic [PW-1:0]   i_pcnt,
  input  logic [CW-1:0]   i_hsize,
  input  logic [CW-1:0]   i_hend,
  input  logic [CW-1:0]   i_hsync_start,
  input  logic [CW-1:0]   i_hsync_end,
  input  logic [CW-1:0]   i_vsize,
  input  logic [CW-1:0]   i_vend,
  input  logic [CW-1:0]   i_vsync_start,
  input  logic [CW-1:0]   i_vsync_end,
  input  logic            i_fifo_empty,
  input  logic [PIXW-1:0] i_fifo_rdata,
  output logic            o_fifo_rd,
  input  logic            i_underflow_clr,
  output logic            o_hsync,
  output logic            o_hblank,
  output logic            o_vsync,
  output logic            o_vblank,
  output logic [CDW-1:0]  o_r,
  output logic [CDW-1:0]  o_g,
  output logic [CDW-1:0]  o_b,
  output logic            o_line_req,
  output logic            o_frame_start,
  output logic            o_underflow
);

  vtg_state_e  r_state;
  vtg_state_e  w_state_nxt;
  timing_cfg_t r_cfg;
  timing_cfg_t w_cfg_in;

  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic [CW-1:0] w_hcnt_nxt;
  logic [CW-1:0] w_vcnt_nxt;

  logic w_run;
  logic w_tick;
  logic w_active;
  logic w_hwrap;
  logic w_frame_wrap;
  logic w_uf_set;
  logic w_line_req_nxt;

  assign w_cfg_in = '{
    hsize:       i_hsize,
    hend:        i_hend,
    hsync_start: i_hsync_start,
    hsync_end:   i_hsync_end,
    vsize:       i_vsize,
    vend:        i_vend,
    vsync_start: i_vsync_start,
    vsync_end:   i_vsync_end,
    pcnt:        i_pcnt
  };

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DISABLED: if (i_en) w_state_nxt = LOAD;
      LOAD:     w_state_nxt = i_en ? RUN : DISABLED;
      RUN:      if (!i_en) w_state_nxt = DISABLED;
      default:  w_state_nxt = DISABLED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= DISABLED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping en is honoured on the same clock, so nothing is popped or counted then.
  assign w_run = (r_state == RUN) && i_en;

  vid_pix_div u_pix_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_run   (w_run),
    .i_pcnt  (r_cfg.pcnt),
    .o_tick  (w_tick)
  );

  assign w_active       = (r_hcnt < r_cfg.hsize) && (r_vcnt < r_cfg.vsize);
  assign w_hwrap        = (r_hcnt == r_cfg.hend - CW'(1));
  assign w_frame_wrap   = w_hwrap && (r_vcnt == r_cfg.vend - CW'(1));
  assign w_hcnt_nxt     = wrap_inc(r_hcnt, r_cfg.hend);
  assign w_vcnt_nxt     = wrap_inc(r_vcnt, r_cfg.vend);
  assign w_line_req_nxt = (r_hcnt == r_cfg.hsize) && (w_vcnt_nxt < r_cfg.vsize);
  assign w_uf_set       = w_run && w_tick && w_active && i_fifo_empty;
  assign o_fifo_rd      = w_run && w_tick && w_active && !i_fifo_empty;

  // Shadow registers: programming changes only take effect at a frame boundary.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cfg <= '0;
    end else if ((r_state == LOAD) || (w_run && w_tick && w_frame_wrap)) begin
      r_cfg <= w_cfg_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_run) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_tick) begin
      r_hcnt <= w_hcnt_nxt;
      if (w_hwrap) begin
        r_vcnt <= w_vcnt_nxt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_run) begin
      o_hsync       <= 1'b0;
      o_hblank      <= 1'b0;
      o_vsync       <= 1'b0;
      o_vblank      <= 1'b0;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
      // Line 0 is requested while loading so the fetch engine gets a head start.
      o_line_req    <= !i_reset && (r_state == LOAD) && i_en;
    end else begin
      o_line_req    <= 1'b0;
      o_frame_start <= 1'b0;
      if (w_uf_set) begin
        o_underflow <= 1'b1;
      end else if (i_underflow_clr) begin
        o_underflow <= 1'b0;
      end
      if (w_tick) begin
        o_hblank      <= !(r_hcnt < r_cfg.hsize);
        o_vblank      <= !(r_vcnt < r_cfg.vsize);
        o_hsync       <= in_window(r_hcnt, r_cfg.hsync_start, r_cfg.hsync_end);
        o_vsync       <= in_window(r_vcnt, r_cfg.vsync_start, r_cfg.vsync_end);
        {o_r, o_g, o_b} <= (w_active && !i_fifo_empty) ? i_fifo_rdata : '0;
        o_line_req    <= w_line_req_nxt;
        o_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: directed scenarios then randomized configs, every clock checked
// against a linear-pixel-index reference model.
module tb_vid_timing_gen;
  import vid_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, en, fifo_empty, uf_clr;
  logic [PW-1:0]   pcnt;
  logic [CW-1:0]   hsize, hend, hss, hse, vsize, vend, vss, vse;
  logic [PIXW-1:0] head;
  logic            o_fifo_rd, o_hsync, o_hblank, o_vsync, o_vblank;
  logic            o_line_req, o_frame_start, o_underflow;
  logic [CDW-1:0]  o_r, o_g, o_b;

  vid_timing_gen dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_pcnt(pcnt),
    .i_hsize(hsize), .i_hend(hend), .i_hsync_start(hss), .i_hsync_end(hse),
    .i_vsize(vsize), .i_vend(vend), .i_vsync_start(vss), .i_vsync_end(vse),
    .i_fifo_empty(fifo_empty), .i_fifo_rdata(head), .o_fifo_rd(o_fifo_rd),
    .i_underflow_clr(uf_clr), .o_hsync(o_hsync), .o_hblank(o_hblank),
    .o_vsync(o_vsync), .o_vblank(o_vblank), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_line_req(o_line_req), .o_frame_start(o_frame_start), .o_underflow(o_underflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: position is one linear pixel index within the frame.
  int m_st;  // 0 disabled, 1 load, 2 run
  int m_pos, m_wait;
  int s_hsize, s_hend, s_hss, s_hse, s_vsize, s_vend, s_vss, s_vse, s_pcnt;
  logic e_hsync, e_hblank, e_vsync, e_vblank, e_lreq, e_fs, e_uf;
  logic [PIXW-1:0] e_rgb;

  int  pop_cnt = 0;
  int  empty_pct = 0;
  bit  force_empty = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int hs, input int he, input int a, input int b,
                         input int vs, input int ve, input int c, input int d, input int p);
    hsize = CW'(hs); hend = CW'(he); hss = CW'(a); hse = CW'(b);
    vsize = CW'(vs); vend = CW'(ve); vss = CW'(c); vse = CW'(d); pcnt = PW'(p);
  endtask

  task automatic model_load();
    s_hsize = int'(hsize); s_hend = int'(hend); s_hss = int'(hss); s_hse = int'(hse);
    s_vsize = int'(vsize); s_vend = int'(vend); s_vss = int'(vss); s_vse = int'(vse);
    s_pcnt  = int'(pcnt);
  endtask

  task automatic model_zero();
    e_hsync = 0; e_hblank = 0; e_vsync = 0; e_vblank = 0;
    e_lreq = 0; e_fs = 0; e_uf = 0; e_rgb = '0;
  endtask

  function automatic bit m_active();
    return (m_pos % s_hend) < s_hsize && (m_pos / s_hend) < s_vsize;
  endfunction

  function automatic bit m_tick();
    return (m_st == 2) && en && (m_wait == s_pcnt);
  endfunction

  task automatic model_edge();
    int h, v;
    bit act;
    if (reset) begin
      model_zero(); m_st = 0; m_pos = 0; m_wait = 0;
    end else if (m_st == 0) begin
      model_zero(); m_st = en ? 1 : 0;
    end else if (m_st == 1) begin
      model_zero(); e_lreq = en; model_load();
      m_pos = 0; m_wait = 0; m_st = en ? 2 : 0;
    end else if (!en) begin
      model_zero(); m_st = 0; m_pos = 0; m_wait = 0;
    end else begin
      h = m_pos % s_hend;
      v = m_pos / s_hend;
      act = m_active();
      e_lreq = 0; e_fs = 0;
      if (m_tick() && act && fifo_empty) e_uf = 1;
      else if (uf_clr) e_uf = 0;
      if (m_tick()) begin
        e_hblank = !(h < s_hsize);
        e_vblank = !(v < s_vsize);
        e_hsync  = (h >= s_hss) && (h < s_hse);
        e_vsync  = (v >= s_vss) && (v < s_vse);
        e_rgb    = (act && !fifo_empty) ? head : '0;
        e_fs     = (m_pos == 0);
        e_lreq   = (h == s_hsize) && (((v + 1) % s_vend) < s_vsize);
        m_wait   = 0;
        if (m_pos == s_hend * s_vend - 1) begin
          m_pos = 0;
          model_load();
        end else begin
          m_pos++;
        end
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic cyc();
    bit popped;
    #2;
    chk("fifo_rd", o_fifo_rd, (m_tick() && m_active() && !fifo_empty));
    popped = o_fifo_rd;
    model_edge();
    @(posedge clk);
    #1;
    if (popped) begin
      pop_cnt++;
      head = PIXW'($urandom);
    end
    fifo_empty = force_empty || (empty_pct > 0 && $urandom_range(0, 99) < empty_pct);
    chk("hsync",  o_hsync,  e_hsync);
    chk("hblank", o_hblank, e_hblank);
    chk("vsync",  o_vsync,  e_vsync);
    chk("vblank", o_vblank, e_vblank);
    chk("rgb",    {o_r, o_g, o_b}, e_rgb);
    chk("line_req",    o_line_req,    e_lreq);
    chk("frame_start", o_frame_start, e_fs);
    chk("underflow",   o_underflow,   e_uf);
  endtask

  task automatic wait_pos(input int tgt);
    int n = 0;
    while (!(m_st == 2 && en && m_wait == s_pcnt && m_pos == tgt) && n < 2000) begin
      cyc();
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $error("FAIL wait_pos obs=timeout exp=pos%0d", tgt);
    end
  endtask

  task automatic measure(output int clks, output int pops);
    int n = 0;
    int p0;
    while (o_frame_start !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
    p0 = pop_cnt;
    clks = 0;
    do begin
      cyc();
      clks++;
    end while (o_frame_start !== 1'b1 && clks < 1000);
    pops = pop_cnt - p0;
  endtask

  initial begin
    int clks, pops, p0, he, ve;
    reset = 1; en = 0; fifo_empty = 0; uf_clr = 0; head = 24'h123456;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_st = 0; m_pos = 0; m_wait = 0; model_zero(); model_load();
    repeat (2) @(posedge clk);
    #1;
    cyc(); cyc();
    reset = 0;

    // Basic frame, pcnt=0
    set_cfg(4, 6, 4, 5, 2, 3, 2, 3, 0);
    en = 1;
    repeat (40) cyc();
    measure(clks, pops);
    chk("t1_frame_clks", clks, 18);
    chk("t1_pops", pops, 8);

    // Divided pixel clock, applied at next frame wrap
    pcnt = 2;
    measure(clks, pops);
    measure(clks, pops);
    chk("t2_frame_clks", clks, 54);
    chk("t2_pops", pops, 8);

    // Underflow on line 0 pixel 2
    wait_pos(2);
    force_empty = 1; fifo_empty = 1;
    cyc();
    force_empty = 0;
    chk("t3_uf_set", o_underflow, 1);
    chk("t3_rgb0", {o_r, o_g, o_b}, 0);
    repeat (10) cyc();
    chk("t3_uf_held", o_underflow, 1);
    uf_clr = 1;
    cyc();
    uf_clr = 0;
    chk("t3_uf_clr", o_underflow, 0);

    // Known head word
    wait_pos(1);
    head = 24'hAABBCC; fifo_empty = 0;
    p0 = pop_cnt;
    cyc();
    chk("t4_rgb", {o_r, o_g, o_b}, 32'h00AABBCC);
    chk("t4_pop_once", pop_cnt - p0, 1);

    // Mid-frame hsize change takes effect next frame
    wait_pos(3);
    hsize = 3;
    measure(clks, pops);
    measure(clks, pops);
    chk("t5_pops", pops, 6);
    chk("t5_frame_clks", clks, 54);
    hsize = 4; pcnt = 0;
    measure(clks, pops);
    measure(clks, pops);
    chk("t5_restore_clks", clks, 18);

    // Disable mid-frame at line1,hcnt3 then re-enable
    wait_pos(9);
    en = 0;
    cyc();
    chk("t6_off", {o_hsync, o_hblank, o_vsync, o_vblank, o_line_req, o_frame_start, o_underflow,
                   o_r, o_g, o_b}, 0);
    en = 1;
    cyc();
    cyc();
    chk("t6_load_lreq", o_line_req, 1);
    cyc();
    chk("t6_first_fs", o_frame_start, 1);

    // Randomized configurations
    for (int k = 0; k < 10; k++) begin
      en = 0;
      cyc();
      he = (k == 0) ? 1 : $urandom_range(1, 10);
      ve = $urandom_range(1, 6);
      set_cfg($urandom_range(1, he), he, $urandom_range(0, he + 1), $urandom_range(0, he + 1),
              $urandom_range(1, ve), ve, $urandom_range(0, ve + 1), $urandom_range(0, ve + 1),
              $urandom_range(0, 3));
      en = 1;
      empty_pct = 10;
      for (int c = 0; c < 300; c++) begin
        uf_clr = ($urandom_range(0, 19) == 0);
        en     = ($urandom_range(0, 199) != 0);
        reset  = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 49) == 0) hsize = CW'($urandom_range(1, int'(hend)));
        cyc();
      end
      reset = 0; uf_clr = 0; en = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
